spi_cmd_ram: RTL



---
 rtl/spi_cmd_ram_if.sv | 20 ++
 rtl/spi_cmd_ram.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ram_if.sv
// Parallel word link between the SPI slave and the command RAM.
// The master side (SPI slave) drives commands; the RAM returns read data and errors.
interface spi_cmd_ram_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       err_clr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    modport master (
        output rx_data, rx_valid, err_clr,
        input  tx_data, tx_valid, cmd_err
    );

    modport slave (
        input  rx_data, rx_valid, err_clr,
        output tx_data, tx_valid, cmd_err
    );
endinterface

// File: rtl/spi_cmd_ram.sv
// Command-decoding single-port RAM behind an SPI slave; read data is held for TX_HOLD cycles.
// Optional macro SPI_CMD_RAM_AUTO_INC_EN: post-increment wr/rd addresses after each data access.
module spi_cmd_ram #(
    parameter int ADDR_W  = 8,
    parameter int TX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_cmd_ram_if.slave  bus
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    logic [7:0]        mem_q [MEM_DEPTH];

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_ok_q, wr_ok_d;
    logic              rd_ok_q, rd_ok_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic              rd_accept;
    logic              cmd_fault;
    op_e               op;
    logic [7:0]        payload;
    logic [ADDR_W-1:0] addr_in;

    assign op      = op_e'(bus.rx_data[9:8]);
    assign payload = bus.rx_data[7:0];
    assign addr_in = payload[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_ok_q   <= 1'b0;
            rd_ok_q   <= 1'b0;
            tx_data_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_ok_q   <= wr_ok_d;
            rd_ok_q   <= rd_ok_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    // Memory is deliberately left out of reset so its contents survive a mid-transfer reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr_q] <= payload;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_ok_d   = wr_ok_q;
        rd_ok_d   = rd_ok_q;
        tx_data_d = tx_data_q;
        mem_we    = 1'b0;
        rd_accept = 1'b0;
        cmd_fault = 1'b0;

        if (bus.rx_valid) begin
            case (op)
                OP_WR_ADDR: begin
                    wr_addr_d = addr_in;
                    wr_ok_d   = 1'b1;
                end
                OP_WR_DATA: begin
                    if (wr_ok_q) begin
                        mem_we = 1'b1;
`ifdef SPI_CMD_RAM_AUTO_INC_EN
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
`endif
                    end else begin
                        cmd_fault = 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    rd_addr_d = addr_in;
                    rd_ok_d   = 1'b1;
                end
                OP_RD_DATA: begin
                    // A read while the previous byte is still being shifted out is a protocol error.
                    if (state_q == IDLE && rd_ok_q) begin
                        rd_accept = 1'b1;
                        tx_data_d = mem_q[rd_addr_q];
`ifdef SPI_CMD_RAM_AUTO_INC_EN
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
`endif
                    end else begin
                        cmd_fault = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    state_d = HOLD;
                    cnt_d   = 8'(TX_HOLD - 1);
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmd_fault) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = (state_q == HOLD);
    assign bus.cmd_err  = err_q;

endmodule
